// File: rtl/tl_sram_bridge_if.sv
// TileLink-UL A/D channel bundle between the crossbar slave port and the SRAM bridge.
interface tl_sram_bridge_if;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [3:0]  a_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        a_valid;
  logic        a_ready;

  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic [5:0]  d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;
  logic        d_valid;
  logic        d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    input  a_ready,
    input  d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
    output d_ready
  );

  modport slave (
    input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    output a_ready,
    output d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
    input  d_ready
  );
endinterface

// File: rtl/tl_sram_bridge.sv
// TileLink-UL slave endpoint: single-beat Get/Put onto a synchronous single-port SRAM,
// one transaction outstanding, AccessAck/AccessAckData returned on the D channel.
module tl_sram_bridge #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [5:0]  SINK_ID    = 6'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tl_sram_bridge_if.slave       tl,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wmask,
  output logic [63:0]           mem_wdata,
  input  logic [63:0]           mem_rdata
);

  localparam int unsigned WORD_LSB = 3;
  localparam int unsigned ADDR_TOP = ADDR_WIDTH + WORD_LSB;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t      state;
  logic        accept_c;
  logic        is_get_c;
  logic        is_put_c;
  logic        deny_c;
  logic [2:0]  align_mask_c;
  logic        unused_a;

  assign unused_a    = ^{tl.a_param, tl.a_corrupt};
  assign tl.d_param  = 2'd0;
  assign tl.d_sink   = SINK_ID;

  // Request decode and the SRAM strobe, both valid only in the accept cycle
  always_comb begin
    accept_c     = tl.a_valid & tl.a_ready;
    is_get_c     = (tl.a_opcode == 3'd4);
    is_put_c     = (tl.a_opcode == 3'd0) | (tl.a_opcode == 3'd1);
    case (tl.a_size)
      3'd0:    align_mask_c = 3'd0;
      3'd1:    align_mask_c = 3'd1;
      3'd2:    align_mask_c = 3'd3;
      default: align_mask_c = 3'd7;
    endcase
    deny_c = ~(is_get_c | is_put_c)
           | (tl.a_size > 3'd3)
           | (|(tl.a_address[2:0] & align_mask_c))
           | (|tl.a_address[63:ADDR_TOP]);

    mem_en    = accept_c & ~deny_c;
    mem_we    = mem_en & is_put_c;
    mem_addr  = mem_en ? tl.a_address[ADDR_TOP-1:WORD_LSB] : '0;
    mem_wmask = mem_we ? tl.a_mask : 8'd0;
    mem_wdata = mem_we ? tl.a_data : 64'd0;
  end

  // a_ready is re-armed one cycle after the D handshake, giving 3/4-cycle accept spacing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tl.a_ready   <= 1'b1;
      tl.d_opcode  <= 3'd0;
      tl.d_size    <= 3'd0;
      tl.d_source  <= 4'd0;
      tl.d_denied  <= 1'b0;
      tl.d_data    <= 64'd0;
      tl.d_corrupt <= 1'b0;
      tl.d_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!tl.a_ready) begin
            tl.a_ready <= 1'b1;
          end else if (tl.a_valid) begin
            tl.a_ready  <= 1'b0;
            tl.d_size   <= tl.a_size;
            tl.d_source <= tl.a_source;
            tl.d_data   <= 64'd0;
            if (deny_c) begin
              state        <= RESP;
              tl.d_valid   <= 1'b1;
              tl.d_denied  <= 1'b1;
              tl.d_opcode  <= is_get_c ? 3'd1 : 3'd0;
              tl.d_corrupt <= is_get_c;
            end else if (is_put_c) begin
              state       <= RESP;
              tl.d_valid  <= 1'b1;
              tl.d_opcode <= 3'd0;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          state       <= RESP;
          tl.d_data   <= mem_rdata;
          tl.d_opcode <= 3'd1;
          tl.d_valid  <= 1'b1;
        end
        RESP: begin
          if (tl.d_ready) begin
            state        <= IDLE;
            tl.d_opcode  <= 3'd0;
            tl.d_size    <= 3'd0;
            tl.d_source  <= 4'd0;
            tl.d_denied  <= 1'b0;
            tl.d_data    <= 64'd0;
            tl.d_corrupt <= 1'b0;
            tl.d_valid   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_sram_bridge.sv
// Directed self-checking bench for tl_sram_bridge with a byte-masked SRAM model.
module tb_tl_sram_bridge;
  logic        clk;
  logic        rst_n;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int checks;
  int errors;

  logic        cap_en;
  logic        cap_we;
  logic [9:0]  cap_addr;
  logic [7:0]  cap_wmask;
  logic [63:0] cap_wdata;

  logic [63:0] mem [1024];

  tl_sram_bridge_if tl ();

  tl_sram_bridge #(.ADDR_WIDTH(10), .SINK_ID(6'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tl        (tl),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM model with byte write enables
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_wmask[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a_ready, presents one request, captures the SRAM strobe, then passes the accept edge
  task automatic send_a(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                        input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
    int n;
    n = 0;
    while (tl.a_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    if (tl.a_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_a_timeout: a_ready=%b want 1", tl.a_ready);
    end
    tl.a_opcode  = op;
    tl.a_size    = size;
    tl.a_source  = src;
    tl.a_address = addr;
    tl.a_mask    = mask;
    tl.a_data    = data;
    tl.a_valid   = 1'b1;
    #1;
    cap_en    = mem_en;
    cap_we    = mem_we;
    cap_addr  = mem_addr;
    cap_wmask = mem_wmask;
    cap_wdata = mem_wdata;
    step();
    tl.a_valid = 1'b0;
  endtask

  task automatic finish_d();
    tl.d_ready = 1'b1;
    step();
    tl.d_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tl.a_opcode = 3'd0; tl.a_param = 3'd0; tl.a_size = 3'd0; tl.a_source = 4'd0;
    tl.a_address = 64'd0; tl.a_mask = 8'd0; tl.a_data = 64'd0; tl.a_corrupt = 1'b0;
    tl.a_valid = 1'b0; tl.d_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (tl.a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b want 1", tl.a_ready); end
    checks++; if (tl.d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b want 0", tl.d_valid); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    checks++; if ({tl.d_opcode, tl.d_denied, tl.d_corrupt, tl.d_sink, tl.d_param} !== 14'd0) begin
      errors++; $display("FAIL reset_d_fields: got %h want 0", {tl.d_opcode, tl.d_denied, tl.d_corrupt, tl.d_sink, tl.d_param}); end
    checks++; if (tl.d_data !== 64'd0) begin errors++; $display("FAIL reset_d_data: got %h want 0", tl.d_data); end
  endtask

  task automatic test_put_get();
    send_a(3'd0, 3'd3, 4'd3, 64'h40, 8'hFF, 64'h1122334455667788);
    checks++; if ({cap_en, cap_we} !== 2'b11) begin errors++; $display("FAIL put_strobe: got %b want 11", {cap_en, cap_we}); end
    checks++; if (cap_addr !== 10'd8) begin errors++; $display("FAIL put_addr: got %0d want 8", cap_addr); end
    checks++; if (cap_wmask !== 8'hFF) begin errors++; $display("FAIL put_wmask: got %h want ff", cap_wmask); end
    checks++; if (cap_wdata !== 64'h1122334455667788) begin errors++; $display("FAIL put_wdata: got %h want 1122334455667788", cap_wdata); end
    checks++; if ({tl.d_valid, tl.d_opcode, tl.d_denied, tl.d_source, tl.d_size} !== {1'b1, 3'd0, 1'b0, 4'd3, 3'd3}) begin
      errors++; $display("FAIL put_ack: got %h want %h", {tl.d_valid, tl.d_opcode, tl.d_denied, tl.d_source, tl.d_size}, {1'b1, 3'd0, 1'b0, 4'd3, 3'd3}); end
    finish_d();
    checks++; if (tl.d_valid !== 1'b0) begin errors++; $display("FAIL put_d_valid_drop: got %b want 0", tl.d_valid); end
    send_a(3'd4, 3'd3, 4'd5, 64'h40, 8'hFF, 64'd0);
    checks++; if ({cap_en, cap_we} !== 2'b10) begin errors++; $display("FAIL get_strobe: got %b want 10", {cap_en, cap_we}); end
    checks++; if (tl.d_valid !== 1'b0) begin errors++; $display("FAIL get_latency_early: got %b want 0", tl.d_valid); end
    step();
    checks++; if ({tl.d_valid, tl.d_opcode, tl.d_denied, tl.d_corrupt, tl.d_source} !== {1'b1, 3'd1, 1'b0, 1'b0, 4'd5}) begin
      errors++; $display("FAIL get_ack: got %h want %h", {tl.d_valid, tl.d_opcode, tl.d_denied, tl.d_corrupt, tl.d_source}, {1'b1, 3'd1, 1'b0, 1'b0, 4'd5}); end
    checks++; if (tl.d_data !== 64'h1122334455667788) begin errors++; $display("FAIL get_data: got %h want 1122334455667788", tl.d_data); end
    finish_d();
  endtask

  task automatic test_partial();
    send_a(3'd1, 3'd3, 4'd2, 64'h40, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
    checks++; if (cap_wmask !== 8'h0F) begin errors++; $display("FAIL partial_wmask: got %h want 0f", cap_wmask); end
    checks++; if ({tl.d_valid, tl.d_opcode} !== {1'b1, 3'd0}) begin errors++; $display("FAIL partial_ack: got %h want 8", {tl.d_valid, tl.d_opcode}); end
    finish_d();
    send_a(3'd4, 3'd3, 4'd2, 64'h40, 8'h01, 64'd0);
    step();
    checks++; if (tl.d_data !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL partial_read: got %h want 11223344aaaaaaaa", tl.d_data); end
    finish_d();
  endtask

  task automatic test_deny();
    send_a(3'd4, 3'd3, 4'd9, 64'h2000, 8'hFF, 64'd0);
    checks++; if (cap_en !== 1'b0) begin errors++; $display("FAIL deny_range_mem_en: got %b want 0", cap_en); end
    checks++; if ({tl.d_valid, tl.d_opcode, tl.d_denied, tl.d_corrupt, tl.d_source} !== {1'b1, 3'd1, 1'b1, 1'b1, 4'd9}) begin
      errors++; $display("FAIL deny_range_ack: got %h want %h", {tl.d_valid, tl.d_opcode, tl.d_denied, tl.d_corrupt, tl.d_source}, {1'b1, 3'd1, 1'b1, 1'b1, 4'd9}); end
    checks++; if (tl.d_data !== 64'd0) begin errors++; $display("FAIL deny_range_data: got %h want 0", tl.d_data); end
    finish_d();
    send_a(3'd4, 3'd1, 4'd1, 64'h41, 8'h02, 64'd0);
    checks++; if ({cap_en, tl.d_valid, tl.d_denied, tl.d_corrupt} !== 4'b0111) begin
      errors++; $display("FAIL deny_misaligned: got %b want 0111", {cap_en, tl.d_valid, tl.d_denied, tl.d_corrupt}); end
    finish_d();
    send_a(3'd2, 3'd3, 4'd4, 64'h48, 8'hFF, 64'd0);
    checks++; if ({cap_en, tl.d_valid, tl.d_opcode, tl.d_denied, tl.d_corrupt} !== {1'b0, 1'b1, 3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL deny_opcode: got %b want %b", {cap_en, tl.d_valid, tl.d_opcode, tl.d_denied, tl.d_corrupt}, {1'b0, 1'b1, 3'd0, 1'b1, 1'b0}); end
    finish_d();
    send_a(3'd0, 3'd4, 4'd4, 64'h48, 8'hFF, 64'd0);
    checks++; if ({cap_en, tl.d_denied} !== 2'b01) begin errors++; $display("FAIL deny_size: got %b want 01", {cap_en, tl.d_denied}); end
    finish_d();
  endtask

  task automatic test_stall();
    int bad;
    send_a(3'd4, 3'd3, 4'd6, 64'h40, 8'hFF, 64'd0);
    step();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tl.a_valid   = ~tl.a_valid;
      tl.a_address = 64'h48 + 64'(i * 8);
      tl.a_source  = 4'(i);
      #1;
      checks++;
      if ({tl.d_valid, tl.d_opcode, tl.d_source, tl.a_ready, mem_en} !== {1'b1, 3'd1, 4'd6, 1'b0, 1'b0}
          || tl.d_data !== 64'h11223344AAAAAAAA) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: got v=%b op=%0d src=%0d rdy=%b en=%b data=%h want 1 1 6 0 0 11223344aaaaaaaa",
                 i, tl.d_valid, tl.d_opcode, tl.d_source, tl.a_ready, mem_en, tl.d_data);
      end
      step();
    end
    tl.a_valid = 1'b0;
    finish_d();
    checks++; if (tl.d_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", tl.d_valid); end
    step();
    checks++; if ({tl.a_ready, tl.d_valid} !== 2'b10) begin errors++; $display("FAIL stall_idle: got %b want 10", {tl.a_ready, tl.d_valid}); end
  endtask

  task automatic test_back_to_back();
    int acc_n;
    int acc_cyc [2];
    int rsp_n;
    logic [3:0] rsp_src [2];
    acc_n = 0; rsp_n = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; rsp_src[0] = 4'd0; rsp_src[1] = 4'd0;
    tl.a_opcode = 3'd0; tl.a_size = 3'd3; tl.a_source = 4'd3; tl.a_address = 64'h80;
    tl.a_mask = 8'hFF; tl.a_data = 64'hCAFE; tl.a_valid = 1'b1; tl.d_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (acc_n == 1) begin tl.a_source = 4'd7; tl.a_address = 64'h88; end
      if (acc_n == 2) tl.a_valid = 1'b0;
      if (tl.d_valid === 1'b1 && rsp_n < 2) begin rsp_src[rsp_n] = tl.d_source; rsp_n++; end
      if (tl.a_ready === 1'b1 && tl.a_valid === 1'b1 && acc_n < 2) begin acc_cyc[acc_n] = c; acc_n++; end
      step();
    end
    tl.a_valid = 1'b0; tl.d_ready = 1'b0;
    checks++; if (acc_n !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", acc_n); end
    checks++; if (acc_cyc[1] - acc_cyc[0] !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d want 3", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (rsp_n !== 2 || rsp_src[0] !== 4'd3 || rsp_src[1] !== 4'd7) begin
      errors++; $display("FAIL b2b_source: got n=%0d %0d,%0d want 2 3,7", rsp_n, rsp_src[0], rsp_src[1]); end
    checks++; if (mem[17] !== 64'hCAFE) begin errors++; $display("FAIL b2b_mem: got %h want cafe", mem[17]); end
  endtask

  task automatic test_reset_mid();
    send_a(3'd4, 3'd3, 4'd8, 64'h88, 8'hFF, 64'd0);
    step();
    checks++; if (tl.d_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", tl.d_valid); end
    rst_n = 1'b0;
    #2;
    checks++; if (tl.d_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async: got %b want 0", tl.d_valid); end
    step();
    rst_n = 1'b1;
    step(); step();
    checks++; if ({tl.a_ready, tl.d_valid} !== 2'b10) begin errors++; $display("FAIL rstmid_idle: got %b want 10", {tl.a_ready, tl.d_valid}); end
    send_a(3'd4, 3'd3, 4'd11, 64'h40, 8'hFF, 64'd0);
    checks++; if (tl.d_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got %b want 0", tl.d_valid); end
    step();
    checks++; if ({tl.d_valid, tl.d_source} !== {1'b1, 4'd11} || tl.d_data !== 64'h11223344AAAAAAAA) begin
      errors++; $display("FAIL rstmid_get: got v=%b src=%0d data=%h want 1 11 11223344aaaaaaaa", tl.d_valid, tl.d_source, tl.d_data); end
    finish_d();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    test_reset();
    test_put_get();
    test_partial();
    test_deny();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
